bf16_operand_pairer: RTL and testbench
======================================

// Module: bf16_operand_pairer
// PURPOSE
//  Upstream feeder for the bf16 adder. Accepts a stream of fp32 values,
//  converts each to bf16 (round-to-nearest-even) and groups consecutive
//  values into (a,b) operand pairs. Buffers the pairs in a small FIFO and
//  presents them downstream with a valid/ready handshake.
// PARAMETERS
//  DEPTH         2   pair FIFO entries (>=1)
//  FLUSH_DENORM  1   1: fp32 denormals -> signed zero; 0: convert as normal bits
// PORTS
//  clock       in   1   rising-edge clock
//  reset       in   1   synchronous, active-high
//  in_data     in   32  fp32 value
//  in_valid    in   1   in_data valid
//  in_last     in   1   last value of a group; an odd element pairs with +0.0
//  in_ready    out  1   value accepted when in_valid & in_ready
//  out_a       out  16  bf16 operand a (FIFO head)
//  out_b       out  16  bf16 operand b (FIFO head)
//  out_valid   out  1   FIFO not empty
//  out_ready   in   1   pair popped when out_valid & out_ready
//  pending     out  1   hold register holds an unpaired first element
// BEHAVIOUR
//  Reset: clears hold and FIFO on the next edge. After reset:
//   out_valid=0, pending=0, out_a=out_b=0. in_ready=0 while reset is high.
//  Conversion (combinational on in_data; f=in_data, e=f[30:23]):
//   - NaN (e==FF, f[22:0]!=0)  -> {f[31],8'hFF,7'h40}
//   - Inf (e==FF, f[22:0]==0)  -> f[31:16]
//   - e==0 with FLUSH_DENORM=1 -> {f[31],15'b0}
//   - else round_up = f[15] & (f[16] | |f[14:0]);
//     result = f[31:16] + round_up. The 16-bit add carries into the
//     exponent, so max finite values round to Inf.
//  Pairing FSM, states EMPTY / HOLD:
//   - EMPTY, accept, !in_last: store bf16 in hold -> HOLD.
//   - EMPTY, accept, in_last: push (bf16, 16'h0000) -> EMPTY.
//   - HOLD, accept: push (hold, bf16) -> EMPTY. in_last is ignored here.
//   - pending = (state==HOLD).
//  Ready rule (no combinational path from in_valid):
//   - full = (count==DEPTH).
//   - in_ready = !reset & (state==EMPTY & !in_last ? 1 : !full | out_ready).
//   - in_ready may depend combinationally on in_last and out_ready.
//  FIFO:
//   - Push and pop in the same cycle are legal, including when full
//     (count unchanged).
//   - Pop when empty is ignored.
//   - Pointers wrap modulo DEPTH.
//   - out_a/out_b hold stable while out_valid & !out_ready.
//  Latency: pair visible on out_* the cycle after the second element
//   (or the in_last element) is accepted.
//  Order is strictly preserved. No value is dropped or duplicated.
//  Reset mid-operation discards held and buffered data.
// TESTING
//  1. 3F800000,40000000, out_ready=1 -> one cycle later out_a=3F80,
//     out_b=4000, out_valid=1 for 1 cycle.
//  2. RNE: 3F808000->3F80, 3F818000->3F82, 3F808001->3F81,
//     3F7FFFFF->3F80; checked as out_a/out_b values.
//  3. Specials: 7F7FFFFF->7F80, 7F800001->7FC0, FF800000->FF80,
//     00400000->0000, 80400000->8000 (FLUSH_DENORM=1).
//  4. Odd group: 3F800000 with in_last=1 -> pair (3F80,0000), pending=0.
//     Next value starts a new pair.
//  5. Backpressure, DEPTH=2, out_ready=0, send 6 values:
//     - values 1-5 accepted; in_ready=0 on value 6; pending=1, count=2;
//     - raise out_ready for 1 cycle: pop (v1,v2), v6 accepted the same
//       cycle, count stays 2.
//  6. Reset asserted with pending=1 and count=2 -> next cycle
//     out_valid=0, pending=0. A following pair emerges normally.

Source files
------------

// File: rtl/bf16_operand_pairer.sv
// fp32 -> bf16 (RNE) converter that groups consecutive values into (a,b) pairs
// and queues them in a small FIFO with a valid/ready output handshake.
module bf16_operand_pairer #(
    parameter int DEPTH        = 2,
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        pending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        hold_reg, hold_next;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [15:0]        a_mem [DEPTH];
    logic [15:0]        b_mem [DEPTH];

    logic [15:0] bf16;
    logic        round_up;
    logic        full, accept, push, pop;
    logic [15:0] push_a, push_b;

    // Rounding carry may ripple into the exponent; max finite rounds to Inf.
    always_comb begin
        round_up = in_data[15] & (in_data[16] | (|in_data[14:0]));
        if (in_data[30:23] == 8'hFF && in_data[22:0] != 23'd0)
            bf16 = {in_data[31], 8'hFF, 7'h40};
        else if (in_data[30:23] == 8'hFF)
            bf16 = in_data[31:16];
        else if (in_data[30:23] == 8'h00 && FLUSH_DENORM)
            bf16 = {in_data[31], 15'd0};
        else
            bf16 = in_data[31:16] + {15'd0, round_up};
    end

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign pending   = (state_reg == HOLD);
    // A first element only needs the hold register, so it never waits on the FIFO.
    assign in_ready  = !reset && ((state_reg == EMPTY && !in_last) || !full || out_ready);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        push       = 1'b0;
        push_a     = bf16;
        push_b     = 16'h0000;
        if (accept) begin
            case (state_reg)
                EMPTY: begin
                    if (in_last) begin
                        push = 1'b1;
                    end else begin
                        hold_next  = bf16;
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    push       = 1'b1;
                    push_a     = hold_reg;
                    push_b     = bf16;
                    state_next = EMPTY;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= EMPTY;
            hold_reg   <= 16'h0000;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is not reset; the head is masked until an entry is valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (push && wr_ptr_reg == PTR_W'(gi)) begin
                    a_mem[gi] <= push_a;
                    b_mem[gi] <= push_b;
                end
            end
        end
    endgenerate

    assign out_a = out_valid ? a_mem[rd_ptr_reg] : 16'h0000;
    assign out_b = out_valid ? b_mem[rd_ptr_reg] : 16'h0000;

endmodule

// File: tb/tb_bf16_operand_pairer.sv
// Directed and randomized bench for bf16_operand_pairer against a queue-based
// reference of pairing, FIFO occupancy and fp32->bf16 rounding.
module tb_bf16_operand_pairer;

    localparam int DEPTH = 2;

    logic        clock;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        out_valid;
    logic        out_ready;
    logic        pending;

    bf16_operand_pairer #(.DEPTH(DEPTH), .FLUSH_DENORM(1'b1)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pending  (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mq[$];
    bit          m_hold;
    logic [15:0] m_hval;
    logic        seen_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Rounding expressed as arithmetic on the discarded low half.
    function automatic logic [15:0] ref_bf16(input logic [31:0] f);
        int unsigned hi, lo, ex, man;
        hi  = f >> 16;
        lo  = f & 32'h0000_FFFF;
        ex  = (f >> 23) & 32'hFF;
        man = f & 32'h007F_FFFF;
        if (ex == 255 && man != 0) return f[31] ? 16'hFFC0 : 16'h7FC0;
        if (ex == 255) return 16'(hi);
        if (ex == 0) return f[31] ? 16'h8000 : 16'h0000;
        if (lo > 32768 || (lo == 32768 && (hi % 2) == 1)) hi = hi + 1;
        return 16'(hi);
    endfunction

    task automatic tick(input bit v, input logic [31:0] d, input bit l, input bit r);
        bit exp_ready, acc, pp;
        logic [15:0] conv;
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
        exp_ready = !reset && ((!m_hold && !l) || mq.size() < DEPTH || r);
        seen_ready = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("pending", 32'(pending), 32'(m_hold));
        if (mq.size() != 0) chk("out_pair", {out_a, out_b}, mq[0]);
        acc = v && exp_ready;
        pp  = r && (mq.size() != 0);
        @(posedge clock);
        if (reset) begin
            mq.delete();
            m_hold = 0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                conv = ref_bf16(d);
                if (m_hold) begin
                    mq.push_back({m_hval, conv});
                    m_hold = 0;
                end else if (l) begin
                    mq.push_back({conv, 16'h0000});
                end else begin
                    m_hold = 1;
                    m_hval = conv;
                end
            end
        end
        @(negedge clock);
        $display("tick v=%0b d=%h l=%0b r=%0b rdy=%0b -> a=%h b=%h ov=%0b pend=%0b",
                 v, d, l, r, seen_ready, out_a, out_b, out_valid, pending);
    endtask

    task automatic chk_head(input string tag, input logic [15:0] a, input logic [15:0] b);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pair"}, {out_a, out_b}, {a, b});
    endtask

    function automatic logic [31:0] rand_fp32();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 6))
            0: x[30:23] = 8'hFF;
            1: x[30:23] = 8'h00;
            2: x[15:0]  = 16'h8000;
            3: x[30:0]  = 31'h7F7F_FFFF;
            4: x[15:0]  = 16'h7FFF;
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        m_hold = 0; m_hval = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        tick(0, 0, 0, 0);
        chk("reset_ready_low", 32'(seen_ready), 32'd0);
        reset = 1'b0;
        tick(0, 0, 0, 0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_out_ab", {out_a, out_b}, 32'd0);

        // Basic pair, one-cycle latency, popped on the next edge
        tick(1, 32'h3F80_0000, 0, 1);
        tick(1, 32'h4000_0000, 0, 1);
        chk_head("t1", 16'h3F80, 16'h4000);
        tick(0, 0, 0, 1);
        chk("t1_popped", 32'(out_valid), 32'd0);

        // Round-to-nearest-even
        tick(1, 32'h3F80_8000, 0, 1);
        tick(1, 32'h3F81_8000, 0, 1);
        chk_head("t2a", 16'h3F80, 16'h3F82);
        tick(1, 32'h3F80_8001, 0, 1);
        tick(1, 32'h3F7F_FFFF, 0, 1);
        chk_head("t2b", 16'h3F81, 16'h3F80);

        // Special values
        tick(1, 32'h7F7F_FFFF, 0, 1);
        tick(1, 32'h7F80_0001, 0, 1);
        chk_head("t3a", 16'h7F80, 16'h7FC0);
        tick(1, 32'hFF80_0000, 0, 1);
        tick(1, 32'h0040_0000, 0, 1);
        chk_head("t3b", 16'hFF80, 16'h0000);
        tick(1, 32'h8040_0000, 1, 1);
        chk_head("t3c", 16'h8000, 16'h0000);

        // Odd group closes with +0.0
        tick(1, 32'h3F80_0000, 1, 1);
        chk_head("t4", 16'h3F80, 16'h0000);
        chk("t4_pending", 32'(pending), 32'd0);
        tick(1, 32'h4000_0000, 0, 1);
        chk("t4_new_pending", 32'(pending), 32'd1);
        tick(1, 32'h3F80_0000, 0, 1);
        chk_head("t4b", 16'h4000, 16'h3F80);
        tick(0, 0, 0, 1);

        // Backpressure with DEPTH=2
        tick(1, 32'h3F80_0000, 0, 0);
        tick(1, 32'h4000_0000, 0, 0);
        tick(1, 32'h4040_0000, 0, 0);
        tick(1, 32'h4080_0000, 0, 0);
        tick(1, 32'h40A0_0000, 0, 0);
        chk("t5_pending", 32'(pending), 32'd1);
        tick(1, 32'h40C0_0000, 0, 0);
        chk("t5_v6_blocked", 32'(seen_ready), 32'd0);
        chk_head("t5_head", 16'h3F80, 16'h4000);
        tick(1, 32'h40C0_0000, 0, 1);
        chk("t5_v6_taken", 32'(seen_ready), 32'd1);
        chk_head("t5_next", 16'h4040, 16'h4080);
        chk("t5_pending_clr", 32'(pending), 32'd0);
        tick(0, 0, 1, 0);
        chk("t5_still_full", 32'(seen_ready), 32'd0);

        // Reset with data held and buffered
        tick(1, 32'h40E0_0000, 0, 0);
        chk("t6_pending", 32'(pending), 32'd1);
        reset = 1'b1;
        tick(0, 0, 0, 0);
        reset = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_pending_clr", 32'(pending), 32'd0);
        tick(1, 32'h4100_0000, 0, 1);
        tick(1, 32'h4110_0000, 0, 1);
        chk_head("t6_after", 16'h4100, 16'h4110);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            if (i == 250) reset = 1'b1;
            if (i == 251) reset = 1'b0;
            tick($urandom_range(0, 3) != 0, rand_fp32(), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 2 * DEPTH + 2; i++) tick(0, 0, 0, 1);
        chk("drain_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
